// File: rtl/cache_pkg.sv
// cache_pkg: shared types, widths and pointer helper for the cache port arbiter
package cache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  function automatic int next_ptr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/cache_port_arbiter_picker.sv
// rr_priority_picker: first requesting port found searching from prio_ptr with wraparound
module rr_priority_picker #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     prio_ptr,
  output logic [PTR_W-1:0]     winner,
  output logic                 any_req
);
  always_comb begin
    winner = '0;
    any_req = |req;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (req[(int'(prio_ptr) + i) % NUM_PORTS]) winner = PTR_W'((int'(prio_ptr) + i) % NUM_PORTS);
  end
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of the single cache core port between requesters
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int PTR_W = $clog2(NUM_PORTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      port_req_i,
  input  logic [NUM_PORTS*32-1:0]   port_addr_i,
  input  logic [NUM_PORTS*32-1:0]   port_wdata_i,
  input  logic [NUM_PORTS-1:0]      port_we_i,
  input  logic [NUM_PORTS*4-1:0]    port_be_i,
  output logic [NUM_PORTS-1:0]      port_gnt_o,
  output logic [NUM_PORTS-1:0]      port_rvalid_o,
  output logic [31:0]               port_rdata_o,
  output logic [NUM_PORTS-1:0]      port_error_o,
  output logic                      cache_req_o,
  output logic [31:0]               cache_addr_o,
  output logic [31:0]               cache_wdata_o,
  output logic                      cache_we_o,
  output logic [3:0]                cache_be_o,
  input  logic                      cache_gnt_i,
  input  logic                      cache_rvalid_i,
  input  logic [31:0]               cache_rdata_i,
  input  logic                      cache_error_i,
  output logic                      busy_o
);
  arb_state_t state, next_state;
  logic [PTR_W-1:0] owner, prio_ptr, winner;
  logic any_req, rsp;
  logic [NUM_PORTS-1:0] owner_oh;
  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) picker (
    .req(port_req_i),
    .prio_ptr(prio_ptr),
    .winner(winner),
    .any_req(any_req)
  );
  always_comb begin
    next_state = (state == IDLE) ? (any_req ? REQ : IDLE)
               : (state == REQ) ? (cache_gnt_i ? WAIT : REQ)
               : (cache_rvalid_i ? IDLE : WAIT);
    owner_oh = NUM_PORTS'(1) << owner;
    rsp = (state == WAIT) && cache_rvalid_i;
    cache_req_o = state == REQ;
    port_gnt_o = (state == REQ && cache_gnt_i) ? owner_oh : '0;
    port_rvalid_o = rsp ? owner_oh : '0;
    port_error_o = (rsp && cache_error_i) ? owner_oh : '0;
    port_rdata_o = rsp ? cache_rdata_i : '0;
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      prio_ptr <= '0;
      cache_addr_o <= '0;
      cache_wdata_o <= '0;
      cache_we_o <= 1'b0;
      cache_be_o <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && any_req) begin
        owner <= winner;
        cache_addr_o <= port_addr_i[int'(winner)*ADDR_W +: ADDR_W];
        cache_wdata_o <= port_wdata_i[int'(winner)*DATA_W +: DATA_W];
        cache_we_o <= port_we_i[winner];
        cache_be_o <= port_be_i[int'(winner)*BE_W +: BE_W];
      end
      if (state == REQ && cache_gnt_i) prio_ptr <= PTR_W'(next_ptr(int'(owner), NUM_PORTS));
    end
  end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: scoreboard bench for 2- and 3-port arbiter instances sharing one cache model
module tb_cache_port_arbiter;
  typedef struct packed {logic [4:0] rv; logic [4:0] er; logic [31:0] d;} rsp_t;
  logic clk, reset;
  logic [1:0] req2, we2, gnt2, rv2, err2;
  logic [63:0] addr2, wd2;
  logic [7:0] be2;
  logic [31:0] rdata2, caddr2, cwd2;
  logic creq2, cwe2, busy2;
  logic [3:0] cbe2;
  logic [2:0] req3, we3, gnt3, rv3, err3;
  logic [95:0] addr3, wd3;
  logic [11:0] be3;
  logic [31:0] rdata3, caddr3, cwd3;
  logic creq3, cwe3, busy3;
  logic [3:0] cbe3;
  logic cgnt, crv, cerr;
  logic [31:0] crdata;
  logic sel;
  logic cur_req, cur_we;
  logic [31:0] cur_addr, cur_wd;
  logic [3:0] cur_be;
  logic [4:0] gq[$];
  rsp_t rq[$];
  logic [4:0] ag, ar, ae, eg;
  logic [31:0] ad;
  rsp_t er;
  int tests = 0, fails = 0;
  cache_port_arbiter #(.NUM_PORTS(2)) dut2 (
    .clk(clk), .reset(reset), .port_req_i(req2), .port_addr_i(addr2), .port_wdata_i(wd2),
    .port_we_i(we2), .port_be_i(be2), .port_gnt_o(gnt2), .port_rvalid_o(rv2), .port_rdata_o(rdata2),
    .port_error_o(err2), .cache_req_o(creq2), .cache_addr_o(caddr2), .cache_wdata_o(cwd2),
    .cache_we_o(cwe2), .cache_be_o(cbe2), .cache_gnt_i(cgnt), .cache_rvalid_i(crv),
    .cache_rdata_i(crdata), .cache_error_i(cerr), .busy_o(busy2)
  );
  cache_port_arbiter #(.NUM_PORTS(3)) dut3 (
    .clk(clk), .reset(reset), .port_req_i(req3), .port_addr_i(addr3), .port_wdata_i(wd3),
    .port_we_i(we3), .port_be_i(be3), .port_gnt_o(gnt3), .port_rvalid_o(rv3), .port_rdata_o(rdata3),
    .port_error_o(err3), .cache_req_o(creq3), .cache_addr_o(caddr3), .cache_wdata_o(cwd3),
    .cache_we_o(cwe3), .cache_be_o(cbe3), .cache_gnt_i(cgnt), .cache_rvalid_i(crv),
    .cache_rdata_i(crdata), .cache_error_i(cerr), .busy_o(busy3)
  );
  assign cur_req = sel ? creq3 : creq2;
  assign cur_addr = sel ? caddr3 : caddr2;
  assign cur_wd = sel ? cwd3 : cwd2;
  assign cur_we = sel ? cwe3 : cwe2;
  assign cur_be = sel ? cbe3 : cbe2;
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset) begin
      ag = {gnt3, gnt2};
      ar = {rv3, rv2};
      ae = {err3, err2};
      ad = rv2 != 0 ? rdata2 : rdata3;
      if (ag != 0) begin
        tests++;
        if (gq.size() == 0) begin
          fails++;
          $display("FAIL gnt_unexpected got=%b", ag);
        end else begin
          eg = gq.pop_front();
          if (ag != eg) begin
            fails++;
            $display("FAIL gnt_order got=%b exp=%b", ag, eg);
          end
        end
      end
      if (ar != 0) begin
        tests++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL rvalid_unexpected got=%b", ar);
        end else begin
          er = rq.pop_front();
          if ({ar, ae, ad} != er) begin
            fails++;
            $display("FAIL rsp got rv=%b err=%b d=%h exp rv=%b err=%b d=%h", ar, ae, ad, er.rv, er.er, er.d);
          end
        end
      end
      tests++;
      if ((rv2 == 0 && rdata2 != 0) || (rv3 == 0 && rdata3 != 0) || (ar == 0 && ae != 0)) begin
        fails++;
        $display("FAIL idle_rsp_zero rdata2=%h rdata3=%h err=%b", rdata2, rdata3, ae);
      end
    end
  end
  task automatic chk(input string n, input logic [68:0] got, input logic [68:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic set2(input int k, input logic r, input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] b);
    req2[k] = r;
    addr2[k*32 +: 32] = a;
    wd2[k*32 +: 32] = d;
    we2[k] = w;
    be2[k*4 +: 4] = b;
  endtask
  task automatic set3(input int k, input logic r, input logic [31:0] a);
    req3[k] = r;
    addr3[k*32 +: 32] = a;
    wd3[k*32 +: 32] = '0;
    we3[k] = 1'b0;
    be3[k*4 +: 4] = 4'hF;
  endtask
  task automatic wait_req(output logic ok);
    for (int i = 0; i < 50 && !cur_req; i++) begin
      @(posedge clk);
      #1;
    end
    ok = cur_req;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL req_timeout got=0 exp=1");
    end
  endtask
  task automatic cache_txn(input int dly, input logic [31:0] rd, input logic err, input logic inst, input int port,
                           input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d, input logic [1:0] drop);
    logic ok;
    logic [4:0] oh;
    oh = 5'(1) << (port + (inst ? 2 : 0));
    gq.push_back(oh);
    rq.push_back('{rv: oh, er: err ? oh : 5'd0, d: rd});
    wait_req(ok);
    if (!ok) return;
    req2 = req2 & ~drop;
    chk("cache_side", {cur_req, cur_addr, cur_we, cur_be, cur_wd}, {1'b1, a, w, b, d});
    for (int i = 0; i < dly; i++) begin
      @(posedge clk);
      #1;
      chk("cache_side_hold", {cur_req, cur_addr, cur_we, cur_be, cur_wd}, {1'b1, a, w, b, d});
    end
    cgnt = 1;
    @(posedge clk);
    #1;
    cgnt = 0;
    chk("req_drop_after_gnt", cur_req, 0);
    crv = 1;
    crdata = rd;
    cerr = err;
    @(posedge clk);
    #1;
    crv = 0;
    crdata = 0;
    cerr = 0;
  endtask
  initial begin
    logic ok;
    reset = 1;
    sel = 0;
    {req2, addr2, wd2, we2, be2} = '0;
    {req3, addr3, wd3, we3, be3} = '0;
    {cgnt, crv, cerr, crdata} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {busy2, busy3}, 0);
    chk("rst_cache_req", {creq2, creq3}, 0);
    chk("rst_cache_side", {cwe2, cbe2, caddr2, cwd2}, 0);
    chk("rst_port_out", {gnt2, rv2, err2, gnt3, rv3, err3}, 0);
    chk("rst_rdata", {rdata2, rdata3}, 0);
    reset = 0;
    set2(0, 1, 32'h0000_0040, 0, 0, 4'hF);
    cache_txn(2, 32'hDEAD_BEEF, 0, 0, 0, 32'h40, 0, 4'hF, 0, 0);
    req2 = 0;
    set2(0, 1, 32'h0000_0044, 0, 0, 4'hF);
    cache_txn(2, 32'h0000_5555, 0, 0, 0, 32'h44, 0, 4'hF, 0, 2'b01);
    req2 = 0;
    set2(1, 1, 32'h0000_0080, 32'h1122_3344, 1, 4'b0101);
    cache_txn(5, 32'h0, 0, 0, 1, 32'h80, 1, 4'b0101, 32'h1122_3344, 0);
    req2 = 0;
    set2(0, 1, 32'h0000_0100, 32'hA0, 0, 4'hF);
    set2(1, 1, 32'h0000_0200, 32'hB0, 0, 4'h3);
    for (int i = 0; i < 6; i++)
      cache_txn(i % 2, 32'h1000 + i, 0, 0, i % 2, (i % 2) ? 32'h200 : 32'h100, 0, (i % 2) ? 4'h3 : 4'hF, (i % 2) ? 32'hB0 : 32'hA0, 0);
    req2 = 0;
    set2(0, 1, 32'h0000_0300, 0, 0, 4'hF);
    wait_req(ok);
    gq.push_back(5'b00001);
    cgnt = 1;
    @(posedge clk);
    #1;
    cgnt = 0;
    req2 = 0;
    chk("wait_busy", busy2, 1);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk("rst_wait_busy", busy2, 0);
    chk("rst_wait_req", creq2, 0);
    crv = 1;
    crdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    crv = 0;
    crdata = 0;
    chk("rst_wait_idle", busy2, 0);
    set2(0, 1, 32'h0000_0100, 32'hA0, 0, 4'hF);
    set2(1, 1, 32'h0000_0200, 32'hB0, 0, 4'h3);
    cache_txn(0, 32'h77, 0, 0, 0, 32'h100, 0, 4'hF, 32'hA0, 0);
    req2 = 0;
    sel = 1;
    for (int k = 0; k < 3; k++) set3(k, 1, 32'h300 + 32'(k) * 16);
    for (int i = 0; i < 4; i++)
      cache_txn(0, 32'hC0 + i, i == 2, 1, i % 3, 32'h300 + 32'(i % 3) * 16, 0, 4'hF, 0, 0);
    req3 = 0;
    sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 69'(gq.size() + rq.size()), 0);
    chk("end_idle", {busy2, busy3}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Round-robin arbiter that shares the single core-side port of the set-associative cache between NUM_PORTS requesters, e.g. instruction fetch (port 0) and load/store unit (port 1).
- Uses the same req/gnt/rvalid handshake on both sides.
- Allows one transaction in flight, because the cache serves one request at a time.
- Latches the winning request so that the cache-side signals stay stable until the cache grants.

Parameters:
- NUM_PORTS, 2, number of requesters (≥2).
- PTR_W, $clog2(NUM_PORTS), width of the owner and priority-pointer registers. Derived; do not override.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- port_req_i  in  NUM_PORTS  per-port request
- port_addr_i  in  NUM_PORTS*32  packed addresses; port k occupies bits [32k+31:32k]
- port_wdata_i  in  NUM_PORTS*32  packed write data
- port_we_i  in  NUM_PORTS  write enable
- port_be_i  in  NUM_PORTS*4  packed byte enables
- port_gnt_o  out  NUM_PORTS  one-hot grant pulse
- port_rvalid_o  out  NUM_PORTS  one-hot response-valid pulse
- port_rdata_o  out  32  response data, shared by all ports, qualified by port_rvalid_o
- port_error_o  out  NUM_PORTS  error, qualified by rvalid
- cache_req_o  out  1  request to cache
- cache_addr_o  out  32  latched address
- cache_wdata_o  out  32  latched write data
- cache_we_o  out  1  latched write enable
- cache_be_o  out  4  latched byte enables
- cache_gnt_i  in  1  cache grant
- cache_rvalid_i  in  1  cache response valid
- cache_rdata_i  in  32  cache read data
- cache_error_i  in  1  cache error
- busy_o  out  1  high while a transaction is owned (state ≠ IDLE)

Behaviour:
- All state changes on posedge clk. Reset is sampled synchronously; when reset=1 at an edge:
  - state=IDLE, owner=0, prio_ptr=0;
  - latched address, write data, write enable and byte enables = 0;
  - every output = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any port_req_i bit is set, the winner is the first requesting port searching prio_ptr, prio_ptr+1, … modulo NUM_PORTS.
  - Latch the winner's addr/wdata/we/be into the cache-side registers and set owner=winner.
  - Next state is REQ. Arbitration costs 1 cycle.
- REQ:
  - cache_req_o=1 and the cache-side data outputs come from the latched registers.
  - port_gnt_o[owner] = cache_gnt_i, combinational passthrough.
  - When cache_gnt_i=1: set prio_ptr = owner+1, wrapping from NUM_PORTS-1 to 0, and go to WAIT.
  - Otherwise stay in REQ with the request unchanged.
- WAIT:
  - cache_req_o=0.
  - When cache_rvalid_i=1:
    - port_rvalid_o[owner]=1 for that cycle;
    - port_error_o[owner]=cache_error_i;
    - port_rdata_o=cache_rdata_i.
  - The next state is IDLE.
- port_rdata_o is 0 in every cycle without rvalid. No port ever sees gnt or rvalid for a transaction it does not own.
- Boundary conditions:
  - Simultaneous requests: strict rotation, so a continuously requesting port waits at most NUM_PORTS-1 transactions.
  - A single requester always wins regardless of prio_ptr.
  - A requester that drops req in REQ before gnt is a protocol violation. The arbiter still completes the latched transaction and routes gnt/rvalid to that owner.
  - cache_gnt_i or cache_rvalid_i asserted outside REQ/WAIT respectively is ignored.
  - prio_ptr modulo arithmetic is correct for NUM_PORTS values that are not a power of 2.
  - Reset in REQ/WAIT: the outstanding transaction is abandoned, no rvalid is issued, and the FSM returns to IDLE.
- Minimum transaction: IDLE→REQ (1 cycle), REQ with immediate gnt (1), WAIT (≥1 cycle, cache-dependent).

Decomposition:
- Shared package cache_pkg holds:
  - arb_state_t enum (IDLE/REQ/WAIT);
  - localparams ADDR_W=32, DATA_W=32, BE_W=4;
  - a priority-pointer increment function.
- One natural sub-module, rr_priority_picker (combinational): inputs req vector and prio_ptr; outputs winner index and any_req. The FSM and latches stay in the top module.

Test Plan:
- Single read: port0 req addr=0x0000_0040, we=0; cache gnt after 2 cycles, rvalid with 0xDEAD_BEEF → port_gnt_o=01 once; port_rvalid_o=01 with rdata=0xDEAD_BEEF; port1 outputs stay 0.
- Contention: both ports hold req continuously for 6 transactions with prio_ptr=0 after reset → grants in order 0,1,0,1,0,1 and cache_addr_o alternates between the two ports' addresses.
- Write passthrough: port1 we=1, be=0b0101, wdata=0x1122_3344 → cache_we_o=1, cache_be_o=0101, cache_wdata_o=0x1122_3344, all stable while cache_gnt_i is held low for 5 cycles.
- Late drop: port0 drops req in REQ before gnt → the cache still gets a latched req; gnt and rvalid both go to port0 only.
- Reset mid-WAIT: assert reset for 1 cycle before cache_rvalid_i → busy_o=0 next cycle; a subsequent cache_rvalid_i pulse produces no port_rvalid_o; prio_ptr=0.
- NUM_PORTS=3, all three requesting → grant order 0,1,2,0; cache_error_i=1 on the third response → port_error_o=100 together with port_rvalid_o=100.
